pulse_sequencer: RTL and testbench

- Burst/periodic trigger scheduler that sits directly upstream of the pulse generator stage.
- Produces a 1-cycle start_evt every cfg_period cycles, repeated cfg_count times or continuously.
- Presents a stable pulse_width value alongside each start_evt for the downstream stage.
- Controlled by software-style start/stop commands; reports busy, done and the running pulse index.

---
 rtl/pulse_pkg.sv | 9 +
 rtl/pulse_sequencer_if.sv | 38 +++
 rtl/pulse_period_cnt.sv | 28 ++
 rtl/pulse_sequencer.sv | 140 ++++++++++++++
 tb/tb_pulse_sequencer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_pkg.sv
// Shared types and sizing constants for the pulse sequencer.
// Optional width-step datapath width lives here as well (PULSE_SEQ_WIDTH_STEP_EN).
package pulse_pkg;
   localparam int PULSE_CNT_W  = 32;
   localparam int PULSE_IDX_W  = 16;
   localparam int PULSE_STEP_W = 16;

   typedef enum logic [1:0] {IDLE, RUN, TAIL} pulse_seq_state_t;
endpackage

// File: rtl/pulse_sequencer_if.sv
// Configuration, command and status bundle between software control and the sequencer.
// cfg_step is present only when PULSE_SEQ_WIDTH_STEP_EN is defined.
interface pulse_sequencer_if
   import pulse_pkg::*;
#(
   parameter int CNT_W = PULSE_CNT_W,
   parameter int IDX_W = PULSE_IDX_W
);
   logic [CNT_W-1:0]               cfg_period;
   logic [CNT_W-1:0]               cfg_width;
   logic [IDX_W-1:0]               cfg_count;
`ifdef PULSE_SEQ_WIDTH_STEP_EN
   logic signed [PULSE_STEP_W-1:0] cfg_step;
`endif
   logic                           cmd_start;
   logic                           cmd_stop;
   logic                           start_evt;
   logic [CNT_W-1:0]               pulse_width;
   logic [IDX_W-1:0]               pulse_idx;
   logic                           busy;
   logic                           done;

   modport master (
`ifdef PULSE_SEQ_WIDTH_STEP_EN
      output cfg_step,
`endif
      output cfg_period, cfg_width, cfg_count, cmd_start, cmd_stop,
      input  start_evt, pulse_width, pulse_idx, busy, done
   );

   modport slave (
`ifdef PULSE_SEQ_WIDTH_STEP_EN
      input  cfg_step,
`endif
      input  cfg_period, cfg_width, cfg_count, cmd_start, cmd_stop,
      output start_evt, pulse_width, pulse_idx, busy, done
   );
endinterface

// File: rtl/pulse_period_cnt.sv
// Free-running 0..period-1 counter with synchronous clear; tick at 0, last at period-1.
// Period must be >= 1; the sequencer clamps it before it reaches here.
module pulse_period_cnt
   import pulse_pkg::*;
#(
   parameter int CNT_W = PULSE_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] period,
   output logic             tick,
   output logic             last
);
   logic [CNT_W-1:0] cnt_q;

   assign tick = (cnt_q == '0);
   assign last = (cnt_q == (period - CNT_W'(1)));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
      end
   end
endmodule

// File: rtl/pulse_sequencer.sv
// Burst/periodic start_evt scheduler; first start_evt one cycle after cmd_start, all outputs registered.
// No backpressure. PULSE_SEQ_WIDTH_STEP_EN adds a saturating per-pulse width step.
module pulse_sequencer
   import pulse_pkg::*;
#(
   parameter int CNT_W = PULSE_CNT_W,
   parameter int IDX_W = PULSE_IDX_W
) (
   input  logic               clk,
   input  logic               rst,
   pulse_sequencer_if.slave   ctl
);
   pulse_seq_state_t state_q, state_d;

   logic [CNT_W-1:0] period_q;
   logic [CNT_W-1:0] width_q;
   logic [IDX_W-1:0] count_q;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             start_evt_q, start_evt_d;
   logic             done_q, done_d;
   logic             busy_q;
   logic             accept;
   logic             burst_end;
   logic             tick;
   logic             last;

`ifdef PULSE_SEQ_WIDTH_STEP_EN
   logic signed [PULSE_STEP_W-1:0] step_q;

   // Bit CNT_W+1 flags a negative sum, bit CNT_W an overflow past the all-ones width.
   function automatic logic [CNT_W-1:0] step_width(input logic [CNT_W-1:0] w,
                                                   input logic signed [PULSE_STEP_W-1:0] s);
      logic signed [CNT_W+1:0] sum;
      sum = $signed({2'b00, w}) + (CNT_W+2)'(s);
      if (sum[CNT_W+1] || (sum == '0)) begin
         return CNT_W'(1);
      end else if (sum[CNT_W]) begin
         return '1;
      end else begin
         return sum[CNT_W-1:0];
      end
   endfunction
`endif

   assign accept    = (state_q == IDLE) && ctl.cmd_start && !ctl.cmd_stop;
   assign burst_end = (count_q != '0) && (idx_q == count_q);

   pulse_period_cnt #(.CNT_W(CNT_W)) u_period_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (accept),
      .en     (state_q != IDLE),
      .period (period_q),
      .tick   (tick),
      .last   (last)
   );

   always_comb begin
      state_d     = state_q;
      start_evt_d = 1'b0;
      done_d      = 1'b0;
      idx_d       = idx_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d     = RUN;
               start_evt_d = 1'b1;
               idx_d       = IDX_W'(1);
            end
         end
         RUN: begin
            // The final pulse is the one showing now (tick); with period 1 the tail is empty.
            if (ctl.cmd_stop) begin
               state_d = IDLE;
            end else if (tick && burst_end) begin
               if (last) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = TAIL;
               end
            end else if (last) begin
               start_evt_d = 1'b1;
               idx_d       = idx_q + IDX_W'(1);
            end
         end
         TAIL: begin
            if (ctl.cmd_stop) begin
               state_d = IDLE;
            end else if (last) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         start_evt_q <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         idx_q       <= '0;
      end else begin
         state_q     <= state_d;
         start_evt_q <= start_evt_d;
         done_q      <= done_d;
         busy_q      <= (state_d != IDLE);
         idx_q       <= idx_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         period_q <= CNT_W'(1);
         width_q  <= '0;
         count_q  <= '0;
`ifdef PULSE_SEQ_WIDTH_STEP_EN
         step_q   <= '0;
`endif
      end else if (accept) begin
         period_q <= (ctl.cfg_period == '0) ? CNT_W'(1) : ctl.cfg_period;
         width_q  <= ctl.cfg_width;
         count_q  <= ctl.cfg_count;
`ifdef PULSE_SEQ_WIDTH_STEP_EN
         step_q   <= ctl.cfg_step;
      end else if (start_evt_q) begin
         width_q  <= step_width(width_q, step_q);
`endif
      end
   end

   assign ctl.start_evt   = start_evt_q;
   assign ctl.pulse_width = width_q;
   assign ctl.pulse_idx   = idx_q;
   assign ctl.busy        = busy_q;
   assign ctl.done        = done_q;
endmodule

// File: tb/tb_pulse_sequencer.sv
// Table-driven and randomized bench for pulse_sequencer against a cycle-offset reference model.
// Width-step checks are compiled in when PULSE_SEQ_WIDTH_STEP_EN is defined.
module tb_pulse_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   pulse_sequencer_if bus_if ();

   pulse_sequencer dut (
      .clk (clk),
      .rst (rst),
      .ctl (bus_if)
   );

   typedef struct {
      int per;
      int wid;
      int cnt;
      int stop_off;
      int restart_off;
      int len;
      int exp_evts;
      int exp_done;
   } vec_t;

   // Reference model state for the burst in flight; offsets count cycles after cmd_start.
   int     m_per;
   int     m_cnt;
   int     m_te;
   longint m_wid;
   longint m_stp;
   int     g_idx;

   function automatic int evts_upto(input int m);
      int k;
      if (m < 1) return 0;
      k = (m - 1) / m_per + 1;
      if (m_cnt != 0 && k > m_cnt) k = m_cnt;
      return k;
   endfunction

   function automatic int min2(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic longint exp_width(input int t);
      longint w;
      int     n;
      w = m_wid;
      n = evts_upto(min2(t - 1, m_te));
`ifdef PULSE_SEQ_WIDTH_STEP_EN
      for (int i = 0; i < n; i++) begin
         w = w + m_stp;
         if (w < 1) w = 1;
         if (w > 64'hFFFF_FFFF) w = 64'hFFFF_FFFF;
      end
`else
      if (n < 0) w = 0;
`endif
      return w;
   endfunction

   task automatic check(input string name, input int t, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0d got 0x%0h expected 0x%0h", name, t, act, exp);
      end
   endtask

   task automatic check_all_idle(input string tag, input int t, input int idx);
      check({tag, "_start_evt"}, t, longint'(bus_if.start_evt), 0);
      check({tag, "_busy"}, t, longint'(bus_if.busy), 0);
      check({tag, "_done"}, t, longint'(bus_if.done), 0);
      check({tag, "_pulse_idx"}, t, longint'(bus_if.pulse_idx), longint'(idx));
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus_if.cmd_start = 1'b0;
         bus_if.cmd_stop  = 1'b0;
      end
   endtask

   task automatic run_burst(input int per, input logic [31:0] wid, input int cnt,
                            input logic signed [15:0] stp, input int stop_off,
                            input int restart_off, input int len,
                            output int n_evt, output int done_t);
      int  m;
      bit  e_evt;
      bit  e_busy;
      bit  e_done;
      int  e_idx;
      m_per = (per == 0) ? 1 : per;
      m_cnt = cnt;
      m_te  = (stop_off == 0) ? 32'h3FFF_FFFF : stop_off;
      m_wid = longint'(wid);
      m_stp = longint'(stp);
      n_evt  = 0;
      done_t = 0;
      @(negedge clk);
      bus_if.cfg_period = per;
      bus_if.cfg_width  = wid;
      bus_if.cfg_count  = cnt[15:0];
`ifdef PULSE_SEQ_WIDTH_STEP_EN
      bus_if.cfg_step   = stp;
`endif
      bus_if.cmd_start  = 1'b1;
      bus_if.cmd_stop   = 1'b0;
      for (int t = 1; t <= len; t++) begin
         @(negedge clk);
         m      = min2(t, m_te);
         e_evt  = (t <= m_te) && (evts_upto(t) != evts_upto(t - 1));
         e_idx  = evts_upto(m) % 65536;
         e_busy = (t <= m_te) && (m_cnt == 0 || t <= m_cnt * m_per);
         e_done = (m_cnt != 0) && (t == m_cnt * m_per + 1) && (m_te > m_cnt * m_per);
         check("start_evt", t, longint'(bus_if.start_evt), longint'(e_evt));
         check("pulse_idx", t, longint'(bus_if.pulse_idx), longint'(e_idx));
         check("busy", t, longint'(bus_if.busy), longint'(e_busy));
         check("done", t, longint'(bus_if.done), longint'(e_done));
         check("pulse_width", t, longint'(bus_if.pulse_width), exp_width(t));
         if (bus_if.start_evt === 1'b1) n_evt++;
         if (bus_if.done === 1'b1) done_t = t;
         g_idx = e_idx;
         // Config noise while busy must not disturb the latched burst.
         bus_if.cmd_start  = (t == restart_off);
         bus_if.cmd_stop   = (t == stop_off);
         bus_if.cfg_period = $urandom_range(0, 9);
         bus_if.cfg_width  = $urandom;
         bus_if.cfg_count  = 16'($urandom_range(0, 9));
`ifdef PULSE_SEQ_WIDTH_STEP_EN
         bus_if.cfg_step   = 16'($urandom);
`endif
      end
      bus_if.cmd_start = 1'b0;
      bus_if.cmd_stop  = 1'b0;
   endtask

   vec_t vecs [8];

   initial begin
      int n_evt;
      int done_t;
      int per;
      int cnt;
      int p_eff;
      int stop_off;
      int restart_off;
      int bw;
      int len;
      logic signed [15:0] stp;

      vecs[0] = '{4, 2,   3, 0,  0, 16, 3, 13};
      vecs[1] = '{0, 7,   2, 0,  0,  6, 2,  3};
      vecs[2] = '{5, 1,   0, 13, 0, 18, 3,  0};
      vecs[3] = '{3, 5,   4, 0,  5, 16, 4, 13};
      vecs[4] = '{2, 100, 1, 0,  0,  5, 1,  3};
      vecs[5] = '{3, 0,   5, 7,  0, 12, 3,  0};
      vecs[6] = '{4, 9,   2, 7,  0, 12, 2,  0};
      vecs[7] = '{1, 3,   1, 0,  0,  4, 1,  2};

      bus_if.cfg_period = '0;
      bus_if.cfg_width  = '0;
      bus_if.cfg_count  = '0;
`ifdef PULSE_SEQ_WIDTH_STEP_EN
      bus_if.cfg_step   = '0;
`endif
      bus_if.cmd_start  = 1'b0;
      bus_if.cmd_stop   = 1'b0;
      g_idx = 0;

      repeat (3) @(negedge clk);
      check_all_idle("reset", 0, 0);
      check("reset_pulse_width", 0, longint'(bus_if.pulse_width), 0);
      rst = 1'b0;
      idle_cycles(2);
      check_all_idle("post_reset", 0, 0);

      for (int i = 0; i < 8; i++) begin
         run_burst(vecs[i].per, vecs[i].wid, vecs[i].cnt, 16'sd0, vecs[i].stop_off,
                   vecs[i].restart_off, vecs[i].len, n_evt, done_t);
         check("vec_evts", i, longint'(n_evt), longint'(vecs[i].exp_evts));
         check("vec_done_cycle", i, longint'(done_t), longint'(vecs[i].exp_done));
         idle_cycles(3);
      end

      // cmd_start together with cmd_stop in IDLE: nothing happens, idx holds.
      @(negedge clk);
      bus_if.cfg_period = 2;
      bus_if.cfg_count  = 3;
      bus_if.cmd_start  = 1'b1;
      bus_if.cmd_stop   = 1'b1;
      for (int t = 1; t <= 5; t++) begin
         @(negedge clk);
         bus_if.cmd_start = 1'b0;
         bus_if.cmd_stop  = 1'b0;
         check_all_idle("start_stop", t, g_idx);
      end

      // Reset while in TAIL of the basic burst, then a clean restart.
      run_burst(4, 32'd2, 3, 16'sd0, 0, 0, 10, n_evt, done_t);
      rst = 1'b1;
      @(negedge clk);
      check_all_idle("mid_rst", 11, 0);
      check("mid_rst_pulse_width", 11, longint'(bus_if.pulse_width), 0);
      rst = 1'b0;
      for (int t = 12; t <= 15; t++) begin
         @(negedge clk);
         check_all_idle("after_rst", t, 0);
      end
      run_burst(4, 32'd2, 3, 16'sd0, 0, 0, 16, n_evt, done_t);
      check("rst_restart_evts", 0, longint'(n_evt), 3);
      check("rst_restart_done", 0, longint'(done_t), 13);
      idle_cycles(2);

`ifdef PULSE_SEQ_WIDTH_STEP_EN
      run_burst(2, 32'd3, 3, -16'sd2, 0, 0, 9, n_evt, done_t);
      check("step_neg_done", 0, longint'(done_t), 7);
      idle_cycles(2);
      run_burst(1, 32'hFFFF_FF00, 3, 16'sh7FFF, 0, 0, 6, n_evt, done_t);
      check("step_pos_done", 0, longint'(done_t), 4);
      idle_cycles(2);
`endif

      for (int r = 0; r < 30; r++) begin
         per   = $urandom_range(0, 6);
         cnt   = $urandom_range(0, 4);
         p_eff = (per == 0) ? 1 : per;
`ifdef PULSE_SEQ_WIDTH_STEP_EN
         stp   = 16'($urandom);
`else
         stp   = 16'sd0;
`endif
         if (cnt == 0) begin
            stop_off = $urandom_range(1, 15);
            len      = stop_off + 3;
            bw       = stop_off;
         end else begin
            stop_off = ($urandom_range(0, 2) == 0) ? $urandom_range(1, cnt * p_eff + 2) : 0;
            len      = cnt * p_eff + 4;
            bw       = (stop_off != 0) ? min2(stop_off, cnt * p_eff) : cnt * p_eff;
         end
         restart_off = ($urandom_range(0, 1) == 1) ? $urandom_range(1, bw) : 0;
         run_burst(per, $urandom, cnt, stp, stop_off, restart_off, len, n_evt, done_t);
         idle_cycles($urandom_range(1, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
